// File: rtl/free_list_if.sv
// Handshake bundle between dispatch/retire/branch logic and the free list.
// The master side drives requests; the slave side (free_list) returns tags and status.
interface free_list_if #(
  parameter int NUM_PREGS = 64,
  parameter int PW        = $clog2(NUM_PREGS)
);
  logic          dequeue_en;
  logic [PW-1:0] dequeue_pr;
  logic          dequeue_valid;
  logic          enqueue_en;
  logic [PW-1:0] enqueue_pr;
  logic [PW:0]   head_ckpt;
  logic          rollback_en;
  logic [PW:0]   rollback_head;
  logic [PW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  modport master (
    output dequeue_en, enqueue_en, enqueue_pr, rollback_en, rollback_head,
    input  dequeue_pr, dequeue_valid, head_ckpt, count, empty, full, overflow
  );

  modport slave (
    input  dequeue_en, enqueue_en, enqueue_pr, rollback_en, rollback_head,
    output dequeue_pr, dequeue_valid, head_ckpt, count, empty, full, overflow
  );
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: one allocate and one free per
// cycle, with head-pointer rollback for branch mispredict recovery.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input  logic          clock,
  input  logic          reset,
  free_list_if.slave    fl
);
  localparam int          PW       = $clog2(NUM_PREGS);
  localparam int          NUM_FREE = NUM_PREGS - NUM_AREGS;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(NUM_PREGS);
  localparam logic [PW:0] TAIL_RST = (PW+1)'(NUM_FREE);

  logic [PW-1:0] r_buf [NUM_PREGS];
  logic [PW:0]   r_head;
  logic [PW:0]   r_tail;
  logic          r_ovf;

  logic [PW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_deq;
  logic          w_enq_req;
  logic          w_enq;
  logic          w_drop;

  // Wrap bit makes tail-head unambiguous: 0 is empty, NUM_PREGS is full.
  assign w_count   = r_tail - r_head;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == FULL_CNT);

  assign w_deq     = fl.dequeue_en & ~w_empty;
  assign w_enq_req = fl.enqueue_en & (fl.enqueue_pr != '0);
  assign w_enq     = w_enq_req & ~w_full;
  assign w_drop    = w_enq_req & w_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        r_buf[i] <= (i < NUM_FREE) ? PW'(NUM_AREGS + i) : '0;
      r_head <= '0;
      r_tail <= TAIL_RST;
      r_ovf  <= 1'b0;
    end else begin
      // Rollback wins over a same-cycle dequeue; retired tags still land at tail.
      if (fl.rollback_en)
        r_head <= fl.rollback_head;
      else if (w_deq)
        r_head <= r_head + 1'b1;
      if (w_enq) begin
        r_buf[r_tail[PW-1:0]] <= fl.enqueue_pr;
        r_tail                <= r_tail + 1'b1;
      end
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign fl.dequeue_pr    = r_buf[r_head[PW-1:0]];
  assign fl.dequeue_valid = ~w_empty;
  assign fl.head_ckpt     = r_head;
  assign fl.count         = w_count;
  assign fl.empty         = w_empty;
  assign fl.full          = w_full;
  assign fl.overflow      = r_ovf;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation order, frees, wrap, rollback,
// overflow and mid-stream reset, with hand-computed expected values.
module tb_free_list;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW        = $clog2(NUM_PREGS);

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [PW:0] ckpt;

  free_list_if #(.NUM_PREGS(NUM_PREGS)) fl_if ();

  free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS)) u_dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fl_if.dequeue_en    = 1'b0;
    fl_if.enqueue_en    = 1'b0;
    fl_if.enqueue_pr    = '0;
    fl_if.rollback_en   = 1'b0;
    fl_if.rollback_head = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state
    chk("rst_count", fl_if.count, 32);
    chk("rst_valid", fl_if.dequeue_valid, 1);
    chk("rst_pr",    fl_if.dequeue_pr, 32);
    chk("rst_empty", fl_if.empty, 0);
    chk("rst_full",  fl_if.full, 0);
    chk("rst_ckpt",  fl_if.head_ckpt, 0);
    chk("rst_ovf",   fl_if.overflow, 0);

    // Drain all 32 initial free tags in order
    for (int i = 0; i < 32; i++) begin
      chk("drain_pr", fl_if.dequeue_pr, 32 + i);
      fl_if.dequeue_en = 1'b1;
      tick();
    end
    chk("drain_empty", fl_if.empty, 1);
    chk("drain_valid", fl_if.dequeue_valid, 0);
    chk("drain_count", fl_if.count, 0);
    tick();
    chk("deq_empty_head", fl_if.head_ckpt, 32);
    chk("deq_empty_count", fl_if.count, 0);

    // Frees 5, 7, 0 from empty; tag 0 is ignored
    fl_if.dequeue_en = 1'b0;
    fl_if.enqueue_en = 1'b1;
    fl_if.enqueue_pr = 6'd5; tick();
    fl_if.enqueue_pr = 6'd7; tick();
    fl_if.enqueue_pr = 6'd0; tick();
    idle();
    chk("enq_count", fl_if.count, 2);
    chk("enq_ovf",   fl_if.overflow, 0);
    chk("enq_pr0",   fl_if.dequeue_pr, 5);
    fl_if.dequeue_en = 1'b1; tick();
    chk("enq_pr1",   fl_if.dequeue_pr, 7);
    tick();
    idle();
    chk("enq_drained", fl_if.count, 0);

    // Simultaneous alloc/free across the tail wrap
    do_reset();
    fl_if.dequeue_en = 1'b1;
    fl_if.enqueue_en = 1'b1;
    fl_if.enqueue_pr = 6'd9;
    for (int i = 0; i < 40; i++) begin
      chk("sim_pr", fl_if.dequeue_pr, (i < 32) ? 32 + i : 9);
      tick();
      chk("sim_count", fl_if.count, 32);
    end
    idle();
    chk("sim_head", fl_if.head_ckpt, 40);

    // Rollback overrides same-cycle dequeue
    do_reset();
    ckpt = fl_if.head_ckpt;
    fl_if.dequeue_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rb_pr", fl_if.dequeue_pr, 32 + i);
      tick();
    end
    chk("rb_pre_count", fl_if.count, 29);
    fl_if.rollback_en   = 1'b1;
    fl_if.rollback_head = ckpt;
    tick();
    idle();
    chk("rb_head",  fl_if.head_ckpt, 0);
    chk("rb_count", fl_if.count, 32);
    chk("rb_pr0",   fl_if.dequeue_pr, 32);

    // Fill to full, then dropped frees set overflow
    do_reset();
    fl_if.enqueue_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      fl_if.enqueue_pr = PW'(i + 1);
      tick();
    end
    chk("full_count", fl_if.count, 64);
    chk("full_flag",  fl_if.full, 1);
    chk("full_ovf0",  fl_if.overflow, 0);
    fl_if.enqueue_pr = 6'd12;
    tick();
    chk("drop_count", fl_if.count, 64);
    chk("drop_ovf",   fl_if.overflow, 1);
    fl_if.dequeue_en = 1'b1;
    tick();
    fl_if.enqueue_en = 1'b0;
    chk("drop_deq_count", fl_if.count, 63);
    chk("drop_deq_full",  fl_if.full, 0);
    chk("drop_deq_ovf",   fl_if.overflow, 1);
    chk("drop_deq_pr",    fl_if.dequeue_pr, 33);

    // Walk head to 47 with 17 free, then reset mid-stream
    for (int i = 0; i < 46; i++) tick();
    idle();
    chk("mid_head",  fl_if.head_ckpt, 47);
    chk("mid_count", fl_if.count, 17);
    chk("mid_pr",    fl_if.dequeue_pr, 16);
    do_reset();
    chk("mrst_head",  fl_if.head_ckpt, 0);
    chk("mrst_count", fl_if.count, 32);
    chk("mrst_ovf",   fl_if.overflow, 0);
    chk("mrst_pr",    fl_if.dequeue_pr, 32);
    chk("mrst_empty", fl_if.empty, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
